rfetch_stage_pipe: RTL and testbench
====================================

Name: rfetch_stage_pipe

Overview:
- Parametrised register-fetch pipeline stage with a valid/ready handshake on both sides, flush support and an internal register file.
- Sits between decode and execute. Captures the decoded instruction fields and the register-file read data into one aligned output register.
- Forwards same-cycle writeback data into the captured operands. While the stage is stalled, it keeps held operands coherent with later writebacks.

Parameters:
- width_p, 32, data word width (bits)
- reg_els_p, 32, number of architectural registers; must be a power of two and >= 2
- read_ports_p, 2, number of source operands per instruction (1..4)
- side_w_p, 64, width of the opaque side-band (control/debug word) carried with the instruction
- addr_w_p, $clog2(reg_els_p), register index width (derived; not overridden)

Ports:
- clk_i  in  1  clock; all state changes on its rising edge
- rst_i  in  1  asynchronous, active-low reset
- flush_i  in  1  kill the held instruction and any instruction being accepted this cycle
- in_v_i  in  1  decode presents a valid instruction
- in_ready_o  out  1  stage can accept this cycle
- in_pc_i  in  width_p  instruction PC
- in_rs_i  in  read_ports_p*addr_w_p  source indices; port k is at bits [k*addr_w_p +: addr_w_p]
- in_rd_i  in  addr_w_p  destination index
- in_imm_i  in  width_p  immediate
- in_side_i  in  side_w_p  side-band word
- out_v_o  out  1  held instruction valid
- out_ready_i  in  1  execute accepts the held instruction
- out_pc_o  out  width_p  registered PC
- out_rs_o  out  read_ports_p*addr_w_p  registered source indices
- out_rd_o  out  addr_w_p  registered destination
- out_imm_o  out  width_p  registered immediate
- out_rs_data_o  out  read_ports_p*width_p  registered operand data; port k is at [k*width_p +: width_p]
- out_side_o  out  side_w_p  registered side-band
- wb_v_i  in  1  writeback write enable
- wb_rd_i  in  addr_w_p  writeback destination
- wb_data_i  in  width_p  writeback data

Behaviour:
- Reset (rst_i low, asynchronous assert, synchronous deassert at the flop inputs):
  - out_v_o = 0.
  - All out_* payload outputs = 0.
  - All register-file entries = 0.
- in_ready_o = !out_v_o || out_ready_i. This is purely combinational and does not depend on in_v_i or flush_i.
- Accept: fires when in_v_i && in_ready_o && !flush_i.
  - Next edge loads every out_* payload field and sets out_v_o = 1.
  - Latency is 1 cycle from accept to out_v_o.
- Drain without refill: out_v_o && out_ready_i && !accept -> next edge out_v_o = 0. Payload is unchanged.
- Stall: out_v_o && !out_ready_i -> all payload outputs hold, apart from the coherence update below.
- Flush: flush_i = 1 -> next edge out_v_o = 0.
  - An in_v_i asserted in the same cycle is dropped and does not load.
  - Flush has priority over accept and over stall.
- Register file:
  - Write on the clock edge when wb_v_i && wb_rd_i != 0.
  - Entry 0 always reads 0 and is never written.
  - Reads are combinational on in_rs_i.
- Capture bypass, per port k:
  - If wb_v_i && wb_rd_i == rs_k && rs_k != 0 in the accept cycle, capture wb_data_i.
  - Otherwise capture the register-file read value (the old value).
  - Result: no write-then-read hazard with a zero-cycle gap.
- Held coherence, per port k:
  - Applies when out_v_o && no accept this cycle && wb_v_i && wb_rd_i == out_rs_k && out_rs_k != 0.
  - The held out_rs_data_o[k] is updated to wb_data_i on the edge.
  - This covers stalls of any length.
- Multiple ports naming the same register all receive the same data.
- A writeback to index 0 has no effect anywhere, including bypass.
- Reset mid-stall: the held instruction is lost and out_v_o = 0 immediately (asynchronous).
- No combinational path from out_ready_i to any out_* output, or from in_* to any out_* output.

Test Plan:
- Reset release, then write x5 = 0x1234 via writeback. Accept an instruction with rs0 = 5, rs1 = 0, pc = 0x100. -> Next cycle out_v_o = 1, out_pc_o = 0x100, out_rs_data_o port0 = 0x1234, port1 = 0.
- Accept rs0 = 7 in the same cycle as wb_v_i = 1, wb_rd_i = 7, wb_data_i = 0xDEADBEEF. -> Captured port0 = 0xDEADBEEF. A repeat with wb_rd_i = 0 and rs0 = 0 gives port0 = 0.
- Hold out_ready_i = 0 for 3 cycles with a held rs1 = 3. Write x3 = 0xA5A5A5A5 in stall cycle 2. -> Payload is stable except port1, which becomes 0xA5A5A5A5. in_ready_o = 0 throughout.
- Back-to-back stream of 4 instructions with out_ready_i = 1 throughout. -> in_ready_o stays 1, 4 consecutive out_v_o cycles, PCs in order with no bubbles.
- Assert flush_i with out_v_o = 1 and in_v_i = 1 in the same cycle. -> Next cycle out_v_o = 0, and the incoming PC never appears on out_pc_o.
- Pull rst_i low asynchronously mid-stall, between clock edges. -> out_v_o and all outputs = 0 before the next edge. After release, x5 reads 0.

Source files
------------

// File: rtl/rfetch_stage_pipe.sv
// Register-fetch pipeline stage: captures decoded fields and register-file
// operands into one aligned output register with valid/ready on both sides.
// Writeback data is bypassed into operands being captured, and operands of a
// held instruction track later writebacks so they never go stale in a stall.
module rfetch_stage_pipe #(
  parameter int width_p      = 32,
  parameter int reg_els_p    = 32,
  parameter int read_ports_p = 2,
  parameter int side_w_p     = 64,
  localparam int addr_w_p    = $clog2(reg_els_p)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic                             in_v_i,
  output logic                             in_ready_o,
  input  logic [width_p-1:0]               in_pc_i,
  input  logic [read_ports_p*addr_w_p-1:0] in_rs_i,
  input  logic [addr_w_p-1:0]              in_rd_i,
  input  logic [width_p-1:0]               in_imm_i,
  input  logic [side_w_p-1:0]              in_side_i,
  output logic                             out_v_o,
  input  logic                             out_ready_i,
  output logic [width_p-1:0]               out_pc_o,
  output logic [read_ports_p*addr_w_p-1:0] out_rs_o,
  output logic [addr_w_p-1:0]              out_rd_o,
  output logic [width_p-1:0]               out_imm_o,
  output logic [read_ports_p*width_p-1:0]  out_rs_data_o,
  output logic [side_w_p-1:0]              out_side_o,
  input  logic                             wb_v_i,
  input  logic [addr_w_p-1:0]              wb_rd_i,
  input  logic [width_p-1:0]               wb_data_i
);

  logic                             out_v_q, out_v_d;
  logic [width_p-1:0]               pc_q, pc_d;
  logic [read_ports_p*addr_w_p-1:0] rs_q, rs_d;
  logic [addr_w_p-1:0]              rd_q, rd_d;
  logic [width_p-1:0]               imm_q, imm_d;
  logic [side_w_p-1:0]              side_q, side_d;
  logic [read_ports_p*width_p-1:0]  data_q, data_d;
  logic [width_p-1:0]               rf_q [reg_els_p];
  logic [width_p-1:0]               rf_d [reg_els_p];
  logic [read_ports_p*width_p-1:0]  cap_data;
  logic                             accept;
  logic                             wb_en;

  // Handshake: ready depends only on the output register state, never on in_v/flush.
  assign in_ready_o = !out_v_q || out_ready_i;
  assign accept     = in_v_i && in_ready_o && !flush_i;
  // Index 0 is hardwired zero, so writes to it are dropped everywhere.
  assign wb_en      = wb_v_i && (wb_rd_i != '0);

  // Register-file next state: a single writeback port.
  always_comb begin
    rf_d = rf_q;
    if (wb_en) rf_d[wb_rd_i] = wb_data_i;
  end

  // Operand capture: same-cycle writeback wins over the stale file value.
  // wb_en already excludes index 0, and entry 0 is never written, so it reads 0.
  always_comb begin
    cap_data = '0;
    for (int k = 0; k < read_ports_p; k++) begin
      if (wb_en && (wb_rd_i == in_rs_i[k*addr_w_p +: addr_w_p]))
        cap_data[k*width_p +: width_p] = wb_data_i;
      else
        cap_data[k*width_p +: width_p] = rf_q[in_rs_i[k*addr_w_p +: addr_w_p]];
    end
  end

  // Output register next state: flush > accept > drain > hold with coherence.
  always_comb begin
    out_v_d = out_v_q;
    pc_d    = pc_q;
    rs_d    = rs_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    side_d  = side_q;
    data_d  = data_q;
    if (flush_i)                      out_v_d = 1'b0;
    else if (accept)                  out_v_d = 1'b1;
    else if (out_v_q && out_ready_i)  out_v_d = 1'b0;
    if (accept) begin
      pc_d   = in_pc_i;
      rs_d   = in_rs_i;
      rd_d   = in_rd_i;
      imm_d  = in_imm_i;
      side_d = in_side_i;
      data_d = cap_data;
    end else if (out_v_q) begin
      // Keep held operands equal to the live architectural value.
      for (int k = 0; k < read_ports_p; k++) begin
        if (wb_en && (wb_rd_i == rs_q[k*addr_w_p +: addr_w_p]))
          data_d[k*width_p +: width_p] = wb_data_i;
      end
    end
  end

  // State registers with asynchronous active-low reset clearing everything.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_v_q <= 1'b0;
      pc_q    <= '0;
      rs_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      side_q  <= '0;
      data_q  <= '0;
      for (int i = 0; i < reg_els_p; i++) rf_q[i] <= '0;
    end else begin
      out_v_q <= out_v_d;
      pc_q    <= pc_d;
      rs_q    <= rs_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      side_q  <= side_d;
      data_q  <= data_d;
      for (int i = 0; i < reg_els_p; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign out_v_o       = out_v_q;
  assign out_pc_o      = pc_q;
  assign out_rs_o      = rs_q;
  assign out_rd_o      = rd_q;
  assign out_imm_o     = imm_q;
  assign out_side_o    = side_q;
  assign out_rs_data_o = data_q;

endmodule

// File: tb/tb_rfetch_stage_pipe.sv
// Testbench for rfetch_stage_pipe: directed scenarios plus a randomized phase,
// all checked against an architectural-level reference model.
module tb_rfetch_stage_pipe;
  localparam int W = 32;
  localparam int N = 32;
  localparam int P = 2;
  localparam int S = 64;
  localparam int A = 5;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic           rst_i, flush_i, in_v_i, in_ready_o, out_v_o, out_ready_i, wb_v_i;
  logic [W-1:0]   in_pc_i, in_imm_i, out_pc_o, out_imm_o, wb_data_i;
  logic [P*A-1:0] in_rs_i, out_rs_o;
  logic [A-1:0]   in_rd_i, out_rd_o, wb_rd_i;
  logic [S-1:0]   in_side_i, out_side_o;
  logic [P*W-1:0] out_rs_data_o;

  rfetch_stage_pipe dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_v_i(in_v_i), .in_ready_o(in_ready_o), .in_pc_i(in_pc_i), .in_rs_i(in_rs_i),
    .in_rd_i(in_rd_i), .in_imm_i(in_imm_i), .in_side_i(in_side_i),
    .out_v_o(out_v_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o),
    .out_rs_o(out_rs_o), .out_rd_o(out_rd_o), .out_imm_o(out_imm_o),
    .out_rs_data_o(out_rs_data_o), .out_side_o(out_side_o),
    .wb_v_i(wb_v_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: architectural register values plus the held instruction.
  logic [W-1:0] mrf [N];
  logic         m_v;
  logic [W-1:0] m_pc, m_imm;
  logic [A-1:0] m_rs [P];
  logic [A-1:0] m_rd;
  logic [S-1:0] m_side;
  logic [W-1:0] m_data [P];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mrf[i] = '0;
    m_v = 1'b0; m_pc = '0; m_imm = '0; m_rd = '0; m_side = '0;
    for (int k = 0; k < P; k++) begin m_rs[k] = '0; m_data[k] = '0; end
  endtask

  // One clock edge of the architectural model, using the inputs now applied.
  // A held or newly captured operand always equals the register's value after
  // this edge's writeback has been applied.
  task automatic model_edge();
    logic acc, was_v;
    acc   = in_v_i && (!m_v || out_ready_i) && !flush_i;
    was_v = m_v;
    if (wb_v_i && wb_rd_i != 0) mrf[wb_rd_i] = wb_data_i;
    if (flush_i) m_v = 1'b0;
    else if (acc) m_v = 1'b1;
    else if (m_v && out_ready_i) m_v = 1'b0;
    if (acc) begin
      m_pc = in_pc_i; m_imm = in_imm_i; m_rd = in_rd_i; m_side = in_side_i;
      for (int k = 0; k < P; k++) m_rs[k] = in_rs_i[k*A +: A];
    end
    if (acc || was_v)
      for (int k = 0; k < P; k++) m_data[k] = mrf[m_rs[k]];
  endtask

  task automatic compare_all(input string tag);
    logic [P*A-1:0] ers;
    logic [P*W-1:0] edata;
    for (int k = 0; k < P; k++) begin
      ers[k*A +: A]   = m_rs[k];
      edata[k*W +: W] = m_data[k];
    end
    check({tag, ".v"},     128'(out_v_o),       128'(m_v));
    check({tag, ".ready"}, 128'(in_ready_o),    128'(!m_v || out_ready_i));
    check({tag, ".pc"},    128'(out_pc_o),      128'(m_pc));
    check({tag, ".rs"},    128'(out_rs_o),      128'(ers));
    check({tag, ".rd"},    128'(out_rd_o),      128'(m_rd));
    check({tag, ".imm"},   128'(out_imm_o),     128'(m_imm));
    check({tag, ".side"},  128'(out_side_o),    128'(m_side));
    check({tag, ".data"},  128'(out_rs_data_o), 128'(edata));
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk_i);
    #1;
    compare_all(tag);
  endtask

  task automatic set_in(input logic v, input logic [W-1:0] pc, input logic [A-1:0] rs0,
                        input logic [A-1:0] rs1);
    in_v_i = v; in_pc_i = pc; in_rs_i = {rs1, rs0};
    in_rd_i = A'(pc[4:0]); in_imm_i = ~pc; in_side_i = {pc, ~pc};
  endtask

  task automatic set_wb(input logic v, input logic [A-1:0] rd, input logic [W-1:0] d);
    wb_v_i = v; wb_rd_i = rd; wb_data_i = d;
  endtask

  initial begin
    rst_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
    set_in(1'b0, '0, '0, '0);
    set_wb(1'b0, '0, '0);
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Write x5 then read it back through an accepted instruction.
    set_wb(1'b1, 5'd5, 32'h1234);
    tick("wb5");
    set_wb(1'b0, '0, '0);
    out_ready_i = 1'b1;
    set_in(1'b1, 32'h100, 5'd5, 5'd0);
    tick("acc100");
    set_in(1'b0, '0, '0, '0);
    check("t1.v",  128'(out_v_o), 128'(1));
    check("t1.pc", 128'(out_pc_o), 128'(32'h100));
    check("t1.d0", 128'(out_rs_data_o[31:0]), 128'(32'h1234));
    check("t1.d1", 128'(out_rs_data_o[63:32]), 128'(0));

    // Same-cycle bypass, then a writeback to x0 which must not bypass.
    set_in(1'b1, 32'h104, 5'd7, 5'd5);
    set_wb(1'b1, 5'd7, 32'hDEADBEEF);
    tick("byp7");
    check("t2.d0", 128'(out_rs_data_o[31:0]), 128'(32'hDEADBEEF));
    set_in(1'b1, 32'h108, 5'd0, 5'd7);
    set_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    tick("byp0");
    check("t2.z0", 128'(out_rs_data_o[31:0]), 128'(0));
    set_wb(1'b0, '0, '0);

    // Three-cycle stall with held rs1 = 3, x3 written in stall cycle 2.
    set_in(1'b1, 32'h10C, 5'd1, 5'd3);
    tick("acc10c");
    out_ready_i = 1'b0;
    set_in(1'b1, 32'h999, 5'd2, 5'd2);
    tick("stall1");
    check("t3.rdy1", 128'(in_ready_o), 128'(0));
    set_wb(1'b1, 5'd3, 32'hA5A5A5A5);
    tick("stall2");
    set_wb(1'b0, '0, '0);
    tick("stall3");
    check("t3.rdy3", 128'(in_ready_o), 128'(0));
    check("t3.pc",   128'(out_pc_o), 128'(32'h10C));
    check("t3.d1",   128'(out_rs_data_o[63:32]), 128'(32'hA5A5A5A5));
    set_in(1'b0, '0, '0, '0);
    out_ready_i = 1'b1;
    tick("drain");

    // Back-to-back stream of four with no bubbles.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'h200 + 32'(4*i), 5'(i), 5'(i+1));
      check("t4.rdy", 128'(in_ready_o), 128'(1));
      tick("stream");
      check("t4.v",  128'(out_v_o), 128'(1));
      check("t4.pc", 128'(out_pc_o), 128'(32'h200 + 32'(4*i)));
    end
    set_in(1'b0, '0, '0, '0);
    tick("stream_end");

    // Flush while holding with a same-cycle incoming instruction.
    set_in(1'b1, 32'h300, 5'd1, 5'd2);
    tick("acc300");
    flush_i = 1'b1;
    set_in(1'b1, 32'h400, 5'd3, 5'd4);
    tick("flush");
    flush_i = 1'b0;
    set_in(1'b0, '0, '0, '0);
    check("t5.v", 128'(out_v_o), 128'(0));
    check("t5.pc", 128'(out_pc_o == 32'h400), 128'(0));
    tick("postflush");
    check("t5.pc2", 128'(out_pc_o == 32'h400), 128'(0));

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      flush_i     = ($urandom_range(0, 15) == 0);
      out_ready_i = ($urandom_range(0, 2) != 0);
      set_in($urandom_range(0, 3) != 0, $urandom, A'($urandom_range(0, 7)),
             A'($urandom_range(0, 7)));
      set_wb($urandom_range(0, 1) == 1, A'($urandom_range(0, 7)), $urandom);
      tick("rand");
    end
    flush_i = 1'b0;
    set_wb(1'b0, '0, '0);

    // Asynchronous reset in the middle of a stall, between edges.
    out_ready_i = 1'b1;
    set_in(1'b1, 32'h500, 5'd5, 5'd6);
    tick("acc500");
    set_in(1'b0, '0, '0, '0);
    out_ready_i = 1'b0;
    tick("stall_r");
    #2;
    rst_i = 1'b0;
    #1;
    model_reset();
    compare_all("arst");
    check("t6.v", 128'(out_v_o), 128'(0));
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b1;
    set_in(1'b1, 32'h600, 5'd5, 5'd5);
    tick("post_rst");
    set_in(1'b0, '0, '0, '0);
    check("t6.x5", 128'(out_rs_data_o), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
